frv_dmem_arbiter: RTL and testbench

Shares the single core data-memory bus between two requesters: port 0, the core LSU request path that the writeback stage completes, and port 1, a secondary master such as an accelerator or debug access.
- Arbitrates the request channel with locked round-robin.
- Records the owner of each accepted transaction in an in-order ID FIFO.
- Routes each memory response (recv/ack/error/rdata) back to its owner.
- Sits between the requesters and the dmem bus; the writeback stage sees an unchanged response handshake on port 0.

---
 rtl/frv_dmem_arbiter_pkg.sv | 12 +
 rtl/frv_dmem_idfifo.sv | 74 +++++++
 rtl/frv_dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_frv_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port identifiers and the
// width of the outstanding-transaction counter.
package frv_dmem_arbiter_pkg;

  // Identifier stored in the ID FIFO for each accepted transaction.
  localparam logic ARB_PORT_LSU = 1'b0;
  localparam logic ARB_PORT_AUX = 1'b1;

  // Wide enough to hold a count of 0..8 outstanding transactions.
  localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/frv_dmem_idfifo.sv
// Circular FIFO of 1-bit owner IDs, one entry per accepted bus transaction.
// The oldest entry (head) identifies the requester owning the next response.
module frv_dmem_idfifo
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 push,
  input  logic                 push_id,
  input  logic                 pop,
  output logic                 head,
  output logic [ARB_CNT_W-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]     mem_q, mem_d;

  // Next-state for pointers, count and storage; callers never push when
  // full or pop when empty.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state, cleared by synchronous reset.
  always_ff @(posedge g_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (g_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ID storage.
  always_ff @(posedge g_clk) begin
    // NOTE: storage is not reset; an entry is only read after it has been written.
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == ARB_CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/frv_dmem_arbiter.sv
// Two-port arbiter in front of the core data-memory bus. Requests are
// arbitrated with locked round-robin; responses return in order to the
// requester recorded in the ID FIFO.
module frv_dmem_arbiter
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  input  logic                 c0_req,
  output logic                 c0_gnt,
  input  logic                 c0_wen,
  input  logic [3:0]           c0_strb,
  input  logic [XLEN-1:0]      c0_addr,
  input  logic [XLEN-1:0]      c0_wdata,
  output logic                 c0_recv,
  input  logic                 c0_ack,
  output logic                 c0_error,
  output logic [XLEN-1:0]      c0_rdata,
  input  logic                 c1_req,
  output logic                 c1_gnt,
  input  logic                 c1_wen,
  input  logic [3:0]           c1_strb,
  input  logic [XLEN-1:0]      c1_addr,
  input  logic [XLEN-1:0]      c1_wdata,
  output logic                 c1_recv,
  input  logic                 c1_ack,
  output logic                 c1_error,
  output logic [XLEN-1:0]      c1_rdata,
  output logic                 m_req,
  input  logic                 m_gnt,
  output logic                 m_wen,
  output logic [3:0]           m_strb,
  output logic [XLEN-1:0]      m_addr,
  output logic [XLEN-1:0]      m_wdata,
  input  logic                 m_recv,
  output logic                 m_ack,
  input  logic                 m_error,
  input  logic [XLEN-1:0]      m_rdata,
  output logic [ARB_CNT_W-1:0] outstanding,
  output logic                 spurious
);

  logic sel_q, sel_d;
  logic lock_q, lock_d;
  logic rr_q, rr_d;
  logic sel, sel_req, accept, pop;
  logic fifo_head, fifo_full, fifo_empty;

  frv_dmem_idfifo #(.DEPTH(OUTSTANDING)) u_idfifo (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .head    (fifo_head),
    .count   (outstanding),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Port selection: a pending (locked) request keeps its port, otherwise
  // a lone requester wins and contention goes to the round-robin favourite.
  always_comb begin
    sel = sel_q;
    if (!lock_q) begin
      unique case ({c1_req, c0_req})
        2'b01:   sel = ARB_PORT_LSU;
        2'b10:   sel = ARB_PORT_AUX;
        2'b11:   sel = rr_q;
        default: sel = sel_q;
      endcase
    end
  end

  // Request path: the selected payload passes straight through; a full ID
  // FIFO blocks the request even if a response pops in the same cycle.
  assign sel_req = (sel == ARB_PORT_AUX) ? c1_req : c0_req;
  assign m_req   = !g_reset && sel_req && !fifo_full;
  assign accept  = m_req && m_gnt;
  assign m_wen   = (sel == ARB_PORT_AUX) ? c1_wen   : c0_wen;
  assign m_strb  = (sel == ARB_PORT_AUX) ? c1_strb  : c0_strb;
  assign m_addr  = (sel == ARB_PORT_AUX) ? c1_addr  : c0_addr;
  assign m_wdata = (sel == ARB_PORT_AUX) ? c1_wdata : c0_wdata;
  assign c0_gnt  = accept && (sel == ARB_PORT_LSU);
  assign c1_gnt  = accept && (sel == ARB_PORT_AUX);

  // Response path: the FIFO head owns the response; data is broadcast.
  assign c0_recv  = !g_reset && m_recv && !fifo_empty && (fifo_head == ARB_PORT_LSU);
  assign c1_recv  = !g_reset && m_recv && !fifo_empty && (fifo_head == ARB_PORT_AUX);
  assign c0_error = m_error && c0_recv;
  assign c1_error = m_error && c1_recv;
  assign c0_rdata = m_rdata;
  assign c1_rdata = m_rdata;
  assign m_ack    = !g_reset && !fifo_empty &&
                    ((fifo_head == ARB_PORT_AUX) ? c1_ack : c0_ack);
  assign pop      = m_recv && m_ack;
  assign spurious = !g_reset && m_recv && fifo_empty;

  // Arbiter next state: lock while a request waits for the bus, and favour
  // the other port after every accept.
  always_comb begin
    sel_d  = sel;
    lock_d = lock_q;
    rr_d   = rr_q;
    if (m_req) lock_d = !m_gnt;
    if (accept) rr_d = !sel;
  end

  // Arbiter state registers.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      sel_q  <= ARB_PORT_LSU;
      lock_q <= 1'b0;
      rr_q   <= ARB_PORT_LSU;
    end else begin
      sel_q  <= sel_d;
      lock_q <= lock_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Directed bench for frv_dmem_arbiter: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_frv_dmem_arbiter;

  localparam int XLEN = 32;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            c0_req, c0_gnt, c0_wen, c0_recv, c0_ack, c0_error;
  logic [3:0]      c0_strb;
  logic [XLEN-1:0] c0_addr, c0_wdata, c0_rdata;
  logic            c1_req, c1_gnt, c1_wen, c1_recv, c1_ack, c1_error;
  logic [3:0]      c1_strb;
  logic [XLEN-1:0] c1_addr, c1_wdata, c1_rdata;
  logic            m_req, m_gnt, m_wen, m_recv, m_ack, m_error;
  logic [3:0]      m_strb;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;
  logic [3:0]      outstanding;
  logic            spurious;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 g_clk = ~g_clk;

  frv_dmem_arbiter #(.XLEN(XLEN), .OUTSTANDING(2)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .c0_req(c0_req), .c0_gnt(c0_gnt), .c0_wen(c0_wen), .c0_strb(c0_strb),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_recv(c0_recv), .c0_ack(c0_ack),
    .c0_error(c0_error), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_gnt(c1_gnt), .c1_wen(c1_wen), .c1_strb(c1_strb),
    .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_recv(c1_recv), .c1_ack(c1_ack),
    .c1_error(c1_error), .c1_rdata(c1_rdata),
    .m_req(m_req), .m_gnt(m_gnt), .m_wen(m_wen), .m_strb(m_strb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_recv(m_recv), .m_ack(m_ack),
    .m_error(m_error), .m_rdata(m_rdata),
    .outstanding(outstanding), .spurious(spurious)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle();
    c0_req = 0; c1_req = 0; c0_ack = 0; c1_ack = 0;
    m_gnt = 0; m_recv = 0; m_error = 0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    idle();
    g_reset = 1;
    tick();
    g_reset = 0;
  endtask

  task automatic test_reset();
    c0_wen = 0; c0_strb = 4'hF; c0_addr = 32'h100; c0_wdata = 32'h1111_1111;
    c1_wen = 1; c1_strb = 4'h3; c1_addr = 32'h200; c1_wdata = 32'h2222_2222;
    idle();
    g_reset = 1;
    tick();
    c0_req = 1; c1_req = 1; m_gnt = 1; m_recv = 1; c0_ack = 1; c1_ack = 1;
    #1;
    total_cnt++; if (m_req !== 1'b0) $display("FAIL rst_m_req: got %b want 0", m_req); else pass_cnt++;
    total_cnt++; if ({c0_gnt, c1_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {c0_gnt, c1_gnt}); else pass_cnt++;
    total_cnt++; if ({c0_recv, c1_recv, m_ack, spurious} !== 4'b0000) $display("FAIL rst_resp: got %b want 0000", {c0_recv, c1_recv, m_ack, spurious}); else pass_cnt++;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL rst_outstanding: got %0d want 0", outstanding); else pass_cnt++;
    idle();
    tick();
    g_reset = 0;
  endtask

  task automatic test_port0_only();
    c0_req = 1; m_gnt = 1;
    #1;
    total_cnt++; if ({m_req, c0_gnt, c1_gnt} !== 3'b110) $display("FAIL p0_gnt: got %b want 110", {m_req, c0_gnt, c1_gnt}); else pass_cnt++;
    total_cnt++; if (m_addr !== 32'h100 || m_strb !== 4'hF || m_wen !== 1'b0) $display("FAIL p0_payload: got %h/%h/%b want 100/f/0", m_addr, m_strb, m_wen); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd1) $display("FAIL p0_out1: got %0d want 1", outstanding); else pass_cnt++;
    m_recv = 1; m_rdata = 32'hDEADBEEF; c0_ack = 1;
    #1;
    total_cnt++; if ({c0_recv, c1_recv, m_ack} !== 3'b101) $display("FAIL p0_recv: got %b want 101", {c0_recv, c1_recv, m_ack}); else pass_cnt++;
    total_cnt++; if (c0_rdata !== 32'hDEADBEEF) $display("FAIL p0_rdata: got %h want deadbeef", c0_rdata); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL p0_out0: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    c0_req = 1; c1_req = 1; m_gnt = 1;
    #1;
    total_cnt++; if ({c0_gnt, c1_gnt} !== 2'b10 || m_addr !== 32'h100) $display("FAIL rr_first: got %b/%h want 10/100", {c0_gnt, c1_gnt}, m_addr); else pass_cnt++;
    tick();
    c0_req = 0;
    #1;
    total_cnt++; if ({c0_gnt, c1_gnt} !== 2'b01 || m_addr !== 32'h200 || m_wdata !== 32'h2222_2222) $display("FAIL rr_second: got %b/%h/%h want 01/200/22222222", {c0_gnt, c1_gnt}, m_addr, m_wdata); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd2) $display("FAIL rr_out2: got %0d want 2", outstanding); else pass_cnt++;
    m_recv = 1; c0_ack = 1; c1_ack = 1; m_rdata = 32'hA;
    #1;
    total_cnt++; if ({c0_recv, c1_recv} !== 2'b10) $display("FAIL rr_resp_a: got %b want 10", {c0_recv, c1_recv}); else pass_cnt++;
    tick();
    m_rdata = 32'hB;
    #1;
    total_cnt++; if ({c0_recv, c1_recv} !== 2'b01 || c1_rdata !== 32'hB) $display("FAIL rr_resp_b: got %b/%h want 01/b", {c0_recv, c1_recv}, c1_rdata); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL rr_out0: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  // rr is 0 here (last accept went to port 1), so an unlocked arbiter would
  // pick port 0 once both request; the lock must keep port 1.
  task automatic test_lock();
    c1_req = 1; m_gnt = 0;
    #1;
    total_cnt++; if (m_req !== 1'b1 || c1_gnt !== 1'b0 || m_addr !== 32'h200) $display("FAIL lk_wait1: got %b/%b/%h want 1/0/200", m_req, c1_gnt, m_addr); else pass_cnt++;
    tick();
    c0_req = 1;
    #1;
    total_cnt++; if (m_addr !== 32'h200 || m_wen !== 1'b1 || c0_gnt !== 1'b0) $display("FAIL lk_hold2: got %h/%b/%b want 200/1/0", m_addr, m_wen, c0_gnt); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (m_addr !== 32'h200) $display("FAIL lk_hold3: got %h want 200", m_addr); else pass_cnt++;
    tick();
    m_gnt = 1;
    #1;
    total_cnt++; if ({c0_gnt, c1_gnt} !== 2'b01) $display("FAIL lk_grant1: got %b want 01", {c0_gnt, c1_gnt}); else pass_cnt++;
    tick();
    c1_req = 0;
    #1;
    total_cnt++; if ({c0_gnt, c1_gnt} !== 2'b10) $display("FAIL lk_grant0: got %b want 10", {c0_gnt, c1_gnt}); else pass_cnt++;
    tick();
    idle();
    m_recv = 1; c0_ack = 1; c1_ack = 1;
    #1;
    total_cnt++; if ({c0_recv, c1_recv} !== 2'b01) $display("FAIL lk_resp_order: got %b want 01", {c0_recv, c1_recv}); else pass_cnt++;
    tick();
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL lk_drain: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  task automatic test_full();
    c0_req = 1; m_gnt = 1;
    tick();
    c0_req = 0; c1_req = 1;
    tick();
    c1_req = 0; c0_req = 1;
    #1;
    total_cnt++; if (outstanding !== 4'd2 || m_req !== 1'b0 || c0_gnt !== 1'b0) $display("FAIL full_block: got %0d/%b/%b want 2/0/0", outstanding, m_req, c0_gnt); else pass_cnt++;
    tick();
    m_recv = 1; c0_ack = 1;
    #1;
    total_cnt++; if (c0_recv !== 1'b1 || m_ack !== 1'b1 || m_req !== 1'b0 || c0_gnt !== 1'b0) $display("FAIL full_nobypass: got %b%b%b%b want 1100", c0_recv, m_ack, m_req, c0_gnt); else pass_cnt++;
    tick();
    m_recv = 0; c0_ack = 0;
    #1;
    total_cnt++; if (outstanding !== 4'd1 || c0_gnt !== 1'b1) $display("FAIL full_after_pop: got %0d/%b want 1/1", outstanding, c0_gnt); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd2) $display("FAIL full_refill: got %0d want 2", outstanding); else pass_cnt++;
    m_recv = 1; c0_ack = 1; c1_ack = 1;
    tick();
    tick();
    idle();
  endtask

  task automatic test_error_backpressure();
    c0_req = 1; m_gnt = 1;
    tick();
    idle();
    m_recv = 1; m_error = 1; c0_ack = 0; c1_ack = 1;
    #1;
    total_cnt++; if ({c0_recv, c0_error, c1_error, c1_recv} !== 4'b1100) $display("FAIL err_route: got %b want 1100", {c0_recv, c0_error, c1_error, c1_recv}); else pass_cnt++;
    total_cnt++; if (m_ack !== 1'b0) $display("FAIL err_noack1: got %b want 0", m_ack); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (outstanding !== 4'd1 || m_ack !== 1'b0) $display("FAIL err_noack2: got %0d/%b want 1/0", outstanding, m_ack); else pass_cnt++;
    tick();
    c0_ack = 1;
    #1;
    total_cnt++; if (m_ack !== 1'b1 || outstanding !== 4'd1) $display("FAIL err_ack: got %b/%0d want 1/1", m_ack, outstanding); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL err_pop: got %0d want 0", outstanding); else pass_cnt++;
  endtask

  task automatic test_spurious();
    m_recv = 1; c0_ack = 1; c1_ack = 1;
    #1;
    total_cnt++; if ({spurious, m_ack, c0_recv, c1_recv} !== 4'b1000) $display("FAIL spur: got %b want 1000", {spurious, m_ack, c0_recv, c1_recv}); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd0 || spurious !== 1'b0) $display("FAIL spur_after: got %0d/%b want 0/0", outstanding, spurious); else pass_cnt++;
  endtask

  // Accept port 1 then port 0 (leaving rr favouring port 1), reset, and
  // confirm the count clears and contention goes back to port 0.
  task automatic test_reset_mid();
    c1_req = 1; m_gnt = 1;
    tick();
    c1_req = 0; c0_req = 1;
    tick();
    idle();
    #1;
    total_cnt++; if (outstanding !== 4'd2) $display("FAIL rm_pre: got %0d want 2", outstanding); else pass_cnt++;
    g_reset = 1;
    tick();
    g_reset = 0;
    c0_req = 1; c1_req = 1; m_gnt = 0;
    #1;
    total_cnt++; if (outstanding !== 4'd0) $display("FAIL rm_out0: got %0d want 0", outstanding); else pass_cnt++;
    total_cnt++; if (m_req !== 1'b1 || m_addr !== 32'h100) $display("FAIL rm_rr0: got %b/%h want 1/100", m_req, m_addr); else pass_cnt++;
    m_recv = 1; c0_ack = 1;
    #1;
    total_cnt++; if (spurious !== 1'b1 || c0_recv !== 1'b0) $display("FAIL rm_ids_gone: got %b/%b want 1/0", spurious, c0_recv); else pass_cnt++;
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_port0_only();
    test_round_robin();
    test_lock();
    test_full();
    test_error_backpressure();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
